// File: rtl/seq_chk_pkg.sv
// Shared types and helpers for the multi-channel trigger/response checker.
// Holds channel state/mode enums and a 32-bit popcount used by the error counter.
package seq_chk_pkg;

  typedef enum logic {IDLE, WAIT} chk_state_t;

  typedef enum logic {MODE_EXACT, MODE_WINDOW} chk_mode_t;

  localparam int unsigned PC_W = 6;

  function automatic logic [PC_W-1:0] popcount(
    input logic [31:0] v
  );
    logic [PC_W-1:0] n;
    n = '0;
    for (int i = 0; i < 32; i++)
      n = n + {{(PC_W-1){1'b0}}, v[i]};
    return n;
  endfunction

endpackage

// File: rtl/seq_chk_chan.sv
// One checker channel: rise detect, IDLE/WAIT FSM, delay counter, optional parity.
// Ports: clk, rst_ (sync, active-high), cfg_delay, cfg_mode, trig, resp,
//   [data, parity, par_err when SEQ_CHK_PARITY_EN], busy, err_det (comb), err_pulse (reg).
module seq_chk_chan
  import seq_chk_pkg::*;
#(
  parameter int DLY_W = 4
`ifdef SEQ_CHK_PARITY_EN
  ,
  parameter int DATA_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic [DLY_W-1:0] cfg_delay,
  input  logic             cfg_mode,
  input  logic             trig,
  input  logic             resp,
`ifdef SEQ_CHK_PARITY_EN
  input  logic [DATA_W-1:0] data,
  input  logic              parity,
  output logic              par_err,
`endif
  output logic             busy,
  output logic             err_det,
  output logic             err_pulse
);

  chk_state_t       state, state_n;
  chk_mode_t        mode, mode_n;
  logic [DLY_W-1:0] cnt, cnt_n;
  logic             trig_q;
  logic             rise;
  logic             pass;
  logic             fail;
  logic             ovl;
  logic             perr;

  assign rise = trig & ~trig_q;
  assign busy = (state == WAIT);

  always_comb begin
    state_n = state;
    mode_n  = mode;
    cnt_n   = cnt;
    pass    = 1'b0;
    fail    = 1'b0;
    ovl     = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          mode_n = chk_mode_t'(cfg_mode);
          if (cfg_delay == '0) begin
            pass = resp;
            fail = ~resp;
          end else if (cfg_mode && resp) begin
            pass = 1'b1;
          end else begin
            state_n = WAIT;
            cnt_n   = cfg_delay - 1'b1;
          end
        end
      end
      WAIT: begin
        // A second rise is flagged and dropped; the in-flight check goes on.
        ovl = rise;
        if (mode == MODE_WINDOW && resp) begin
          pass    = 1'b1;
          state_n = IDLE;
        end else if (cnt == '0) begin
          pass    = resp;
          fail    = ~resp;
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

`ifdef SEQ_CHK_PARITY_EN
  assign perr = pass & (^data ^ parity);
`else
  assign perr = 1'b0;
`endif

  assign err_det = fail | ovl | perr;

  always_ff @(posedge clk) begin
    if (rst_) begin
      state     <= IDLE;
      mode      <= MODE_EXACT;
      cnt       <= '0;
      trig_q    <= 1'b1;
      err_pulse <= 1'b0;
`ifdef SEQ_CHK_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      mode      <= mode_n;
      cnt       <= cnt_n;
      trig_q    <= trig;
      err_pulse <= err_det;
`ifdef SEQ_CHK_PARITY_EN
      par_err   <= perr;
`endif
    end
  end

endmodule

// File: rtl/seq_delay_checker.sv
// Multi-channel "rise(trig) -> resp within D cycles" checker with sticky flags and count.
// Ports: clk, rst_, cfg_delay, cfg_mode, trig, resp, err_clr, busy, err_pulse,
//   err_flag, err_cnt; data/parity/par_err added when SEQ_CHK_PARITY_EN is defined.
module seq_delay_checker
  import seq_chk_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DLY_W  = 4,
  parameter int CNT_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic [DLY_W-1:0]  cfg_delay,
  input  logic              cfg_mode,
  input  logic [NCH-1:0]    trig,
  input  logic [NCH-1:0]    resp,
  input  logic              err_clr,
`ifdef SEQ_CHK_PARITY_EN
  input  logic [NCH*DATA_W-1:0] data,
  input  logic [NCH-1:0]        parity,
  output logic [NCH-1:0]        par_err,
`endif
  output logic [NCH-1:0]    busy,
  output logic [NCH-1:0]    err_pulse,
  output logic [NCH-1:0]    err_flag,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int SW = CNT_W + PC_W;
  localparam logic [SW-1:0] MAXV = {{PC_W{1'b0}}, {CNT_W{1'b1}}};

  if (NCH < 1 || NCH > 32 || DATA_W < 1) begin : g_bad_cfg
    $error("seq_delay_checker: NCH must be 1..32 and DATA_W >= 1");
  end

  logic [NCH-1:0]  det;
  logic [31:0]     det32;
  logic [PC_W-1:0] pc;
  logic [SW-1:0]   base;
  logic [SW-1:0]   sum;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    seq_chk_chan #(
      .DLY_W (DLY_W)
`ifdef SEQ_CHK_PARITY_EN
      ,
      .DATA_W(DATA_W)
`endif
    ) u_chan (
      .clk      (clk),
      .rst_     (rst_),
      .cfg_delay(cfg_delay),
      .cfg_mode (cfg_mode),
      .trig     (trig[i]),
      .resp     (resp[i]),
`ifdef SEQ_CHK_PARITY_EN
      .data     (data[i*DATA_W +: DATA_W]),
      .parity   (parity[i]),
      .par_err  (par_err[i]),
`endif
      .busy     (busy[i]),
      .err_det  (det[i]),
      .err_pulse(err_pulse[i])
    );
  end

  // Flags and count are fed from the same detections that register
  // err_pulse, so all three change on the same edge; set beats clear.
  assign det32 = 32'(det);
  assign pc    = popcount(det32);
  assign base  = err_clr ? '0 : {{PC_W{1'b0}}, err_cnt};
  assign sum   = base + {{CNT_W{1'b0}}, pc};

  always_ff @(posedge clk) begin
    if (rst_) begin
      err_flag <= '0;
      err_cnt  <= '0;
    end else begin
      err_flag <= (err_clr ? '0 : err_flag) | det;
      err_cnt  <= (sum > MAXV) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_seq_delay_checker.sv
// Directed + random bench for seq_delay_checker against a start-time/deadline model.
module tb_seq_delay_checker;

  localparam int NCH    = 4;
  localparam int DLY_W  = 4;
  localparam int CNT_W  = 3;
  localparam int DATA_W = 8;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_;
  logic [DLY_W-1:0] cfg_delay;
  logic             cfg_mode;
  logic [NCH-1:0]   trig;
  logic [NCH-1:0]   resp;
  logic             err_clr;
  logic [NCH-1:0]   busy;
  logic [NCH-1:0]   err_pulse;
  logic [NCH-1:0]   err_flag;
  logic [CNT_W-1:0] err_cnt;
`ifdef SEQ_CHK_PARITY_EN
  logic [NCH*DATA_W-1:0] data;
  logic [NCH-1:0]        parity;
  logic [NCH-1:0]        par_err;
`endif

  seq_delay_checker #(
    .NCH(NCH), .DLY_W(DLY_W), .CNT_W(CNT_W), .DATA_W(DATA_W)
  ) dut (
    .clk      (clk),
    .rst_     (rst_),
    .cfg_delay(cfg_delay),
    .cfg_mode (cfg_mode),
    .trig     (trig),
    .resp     (resp),
    .err_clr  (err_clr),
`ifdef SEQ_CHK_PARITY_EN
    .data     (data),
    .parity   (parity),
    .par_err  (par_err),
`endif
    .busy     (busy),
    .err_pulse(err_pulse),
    .err_flag (err_flag),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: each channel holds an optional pending check
  // described by its start cycle, deadline offset and mode
  int             cyc = 0;
  bit [NCH-1:0]   act;
  int             st[NCH];
  int             dl[NCH];
  bit             md[NCH];
  bit [NCH-1:0]   tprev;
  bit [NCH-1:0]   m_pulse;
  bit [NCH-1:0]   m_flag;
  bit [NCH-1:0]   m_perr;
  int             m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit [NCH-1:0] ep;
    bit [NCH-1:0] pe;
    int n;
    ep = '0;
    pe = '0;
    if (rst_) begin
      act = '0; tprev = '1; m_pulse = '0; m_flag = '0;
      m_perr = '0; m_cnt = 0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        bit r, ok;
        r  = trig[i] & ~tprev[i];
        ok = 1'b0;
        if (act[i]) begin
          if (md[i] && resp[i]) begin ok = 1; act[i] = 0; end
          else if (cyc == st[i] + dl[i]) begin
            if (resp[i]) ok = 1; else ep[i] = 1;
            act[i] = 0;
          end
          if (r) ep[i] = 1;
        end else if (r) begin
          st[i] = cyc; dl[i] = int'(cfg_delay); md[i] = cfg_mode;
          if (dl[i] == 0) begin
            if (resp[i]) ok = 1; else ep[i] = 1;
          end else if (md[i] && resp[i]) ok = 1;
          else act[i] = 1;
        end
`ifdef SEQ_CHK_PARITY_EN
        if (ok && ((^data[i*DATA_W +: DATA_W]) ^ parity[i])) begin
          ep[i] = 1; pe[i] = 1;
        end
`endif
      end
      tprev = trig;
      m_pulse = ep;
      m_perr = pe;
      m_flag = (err_clr ? '0 : m_flag) | ep;
      n = (err_clr ? 0 : m_cnt) + $countones(ep);
      m_cnt = (n > CMAX) ? CMAX : n;
    end
    cyc++;
  endtask

  task automatic cycle();
    model_step();
    @(negedge clk);
    chk("busy", 32'(busy), 32'(act));
    chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
    chk("err_flag", 32'(err_flag), 32'(m_flag));
    chk("err_cnt", 32'(err_cnt), m_cnt);
`ifdef SEQ_CHK_PARITY_EN
    chk("par_err", 32'(par_err), 32'(m_perr));
`endif
  endtask

  task automatic drv(input logic [NCH-1:0] t, input logic [NCH-1:0] r,
                     input int d, input bit m, input bit clr = 1'b0);
    rst_ = 1'b0;
    trig = t;
    resp = r;
    cfg_delay = d[DLY_W-1:0];
    cfg_mode = m;
    err_clr = clr;
    cycle();
  endtask

  initial begin
    rst_ = 1'b1; trig = '1; resp = '0; cfg_delay = '0;
    cfg_mode = 1'b0; err_clr = 1'b0;
`ifdef SEQ_CHK_PARITY_EN
    data = '0; parity = '0;
`endif
    cycle();
    cycle();
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    drv(4'hF, 0, 0, 0);
    chk("no_rise_after_rst", 32'(err_pulse), 0);
    drv(0, 0, 0, 0);

    // exact D=3 pass, cfg changed mid-check
    drv(1, 0, 3, 0);
    drv(1, 0, 7, 1);
    chk("exact_busy", 32'(busy), 1);
    drv(1, 0, 7, 1);
    drv(1, 1, 7, 1);
    chk("exact_pass_cnt", 32'(err_cnt), 0);
    drv(0, 0, 7, 1);

    // exact D=3 early response fails
    drv(1, 0, 3, 0);
    drv(1, 0, 3, 0);
    drv(1, 1, 3, 0);
    drv(1, 0, 3, 0);
    chk("exact_fail_cnt", 32'(err_cnt), 1);
    chk("exact_fail_flag", 32'(err_flag), 1);
    drv(0, 0, 3, 0);

    // window D=5 pass at t+2, then no response
    drv(1, 0, 5, 1);
    drv(1, 0, 5, 1);
    drv(1, 1, 5, 1);
    chk("win_busy_drop", 32'(busy), 0);
    drv(0, 0, 5, 1);
    drv(1, 0, 5, 1);
    for (int k = 0; k < 5; k++) drv(1, 0, 5, 1);
    chk("win_fail_pulse", 32'(err_pulse), 1);
    drv(0, 0, 0, 0);

    // D=0 on ch1, overlap on ch2
    drv(2, 0, 0, 0);
    chk("d0_pulse", 32'(err_pulse), 2);
    drv(0, 0, 3, 0);
    drv(4, 0, 3, 0);
    drv(0, 0, 3, 0);
    drv(4, 0, 3, 0);
    chk("ovl_pulse", 32'(err_pulse), 4);
    drv(4, 4, 3, 0);
    chk("ovl_done", 32'(busy), 0);

    // saturation, then clear together with a new error
    drv(0, 0, 0, 0);
    drv(4'hF, 0, 0, 0);
    drv(0, 0, 0, 0);
    drv(4'hF, 0, 0, 0);
    chk("sat_cnt", 32'(err_cnt), CMAX);
    drv(0, 0, 0, 0);
    drv(2, 0, 0, 0, 1'b1);
    chk("clr_set_cnt", 32'(err_cnt), 1);
    chk("clr_set_flag", 32'(err_flag), 2);

    // reset in the middle of a wait with trig held high
    drv(0, 0, 0, 0);
    drv(1, 0, 9, 0);
    drv(1, 0, 9, 0);
    rst_ = 1'b1;
    cycle();
    for (int k = 0; k < 12; k++) drv(1, 0, 9, 0);
    chk("rst_wait_cnt", 32'(err_cnt), 0);

`ifdef SEQ_CHK_PARITY_EN
    drv(0, 0, 0, 0);
    data = '0; data[0] = 1'b1; parity = '0;
    drv(1, 0, 3, 1);
    drv(1, 1, 3, 1);
    chk("par_err", 32'(par_err), 1);
    data = '0;
`endif

    for (int k = 0; k < 3000; k++) begin
`ifdef SEQ_CHK_PARITY_EN
      for (int i = 0; i < NCH; i++) begin
        data[i*DATA_W +: DATA_W] = DATA_W'($urandom);
        parity[i] = (^data[i*DATA_W +: DATA_W]) ^
                    ($urandom_range(0, 7) == 0);
      end
`endif
      rst_      = ($urandom_range(0, 199) == 0);
      trig      = NCH'($urandom);
      resp      = NCH'($urandom);
      cfg_delay = DLY_W'($urandom_range(0, 5));
      cfg_mode  = 1'($urandom);
      err_clr   = ($urandom_range(0, 15) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
